// File: rtl/scan_mux.sv
// scan_mux: registered N-channel selector with manual select and auto-scan with dwell
module scan_mux #(
    parameter int N_CH  = 8,
    parameter int W     = 1,
    parameter int SEL_W = $clog2(N_CH),
    parameter int DWELL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              G_n,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    input  logic [N_CH*W-1:0] D,
    output logic [W-1:0]      F,
    output logic [W-1:0]      F_n,
    output logic [SEL_W-1:0]  ch,
    output logic              valid,
    output logic              wrap
);
    localparam int DW_W = DWELL > 1 ? $clog2(DWELL) : 1;

    logic [SEL_W-1:0] cnt;
    logic [DW_W-1:0]  dw;
    logic [W-1:0]     d_sel;
    logic [W-1:0]     d_cnt;
    logic             hit;
    logic             last_dw;
    logic             last_ch;

    assign F_n     = ~F;
    assign last_dw = dw == DW_W'(DWELL - 1);
    assign last_ch = cnt == SEL_W'(N_CH - 1);

    // pick manual and scan channel data; hit flags an in-range manual select
    always_comb begin
        d_sel = '0;
        d_cnt = '0;
        hit   = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel == SEL_W'(k)) begin
                d_sel = D[k*W +: W];
                hit   = 1'b1;
            end
            if (cnt == SEL_W'(k)) d_cnt = D[k*W +: W];
        end
    end

    // output register plus scan channel/dwell counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            F     <= '0;
            ch    <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
            cnt   <= '0;
            dw    <= '0;
        end else begin
            if (!mode) begin
                cnt <= '0;
                dw  <= '0;
            end
            if (G_n) begin
                F     <= '0;
                valid <= 1'b0;
                wrap  <= 1'b0;
            end else if (!mode) begin
                F     <= hit ? d_sel : '0;
                valid <= hit;
                wrap  <= 1'b0;
                if (hit) ch <= sel;
            end else begin
                F     <= d_cnt;
                ch    <= cnt;
                valid <= 1'b1;
                wrap  <= last_dw && last_ch;
                dw    <= last_dw ? '0 : dw + DW_W'(1);
                if (last_dw) cnt <= last_ch ? '0 : cnt + SEL_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: two scan_mux configurations checked against a dwell-position reference model
module tb_scan_mux;
    logic        clk = 1'b0;
    logic        rst_n, G_n, mode;
    logic [2:0]  sel_a, sel_b;
    logic [7:0]  d_a;
    logic [19:0] d_b;
    logic        f_a, fn_a, valid_a, wrap_a;
    logic [2:0]  ch_a, ch_b;
    logic [3:0]  f_b, fn_b;
    logic        valid_b, wrap_b;

    int n_chk = 0;
    int n_pass = 0;
    int nch[2] = '{8, 5};
    int wd[2]  = '{1, 4};
    int dwl[2] = '{1, 3};
    int k[2], ch_m[2], f_m[2], v_m[2], w_m[2];

    scan_mux #(.N_CH(8), .W(1), .DWELL(1)) u_a (
        .clk(clk), .rst_n(rst_n), .G_n(G_n), .mode(mode), .sel(sel_a), .D(d_a),
        .F(f_a), .F_n(fn_a), .ch(ch_a), .valid(valid_a), .wrap(wrap_a)
    );

    scan_mux #(.N_CH(5), .W(4), .DWELL(3)) u_b (
        .clk(clk), .rst_n(rst_n), .G_n(G_n), .mode(mode), .sel(sel_b), .D(d_b),
        .F(f_b), .F_n(fn_b), .ch(ch_b), .valid(valid_b), .wrap(wrap_b)
    );

    always #5 clk = ~clk;

    function automatic int field(logic [31:0] d, int c, int w);
        logic [31:0] m;
        m = (32'h1 << w) - 32'h1;
        return int'((d >> (c * w)) & m);
    endfunction

    // k counts enabled scan cycles since scan start; channel and wrap follow from it
    task automatic model(int i, logic [31:0] d, int s);
        int c, p;
        p = nch[i] * dwl[i];
        if (!rst_n) begin
            f_m[i] = 0; ch_m[i] = 0; v_m[i] = 0; w_m[i] = 0; k[i] = 0;
        end else if (G_n) begin
            f_m[i] = 0; v_m[i] = 0; w_m[i] = 0;
            if (!mode) k[i] = 0;
        end else if (!mode) begin
            k[i] = 0;
            w_m[i] = 0;
            v_m[i] = int'(s < nch[i]);
            f_m[i] = s < nch[i] ? field(d, s, wd[i]) : 0;
            if (s < nch[i]) ch_m[i] = s;
        end else begin
            c = (k[i] / dwl[i]) % nch[i];
            f_m[i] = field(d, c, wd[i]);
            ch_m[i] = c;
            v_m[i] = 1;
            w_m[i] = int'(k[i] == p - 1);
            k[i] = (k[i] + 1) % p;
        end
    endtask

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        model(0, {24'b0, d_a}, int'(sel_a));
        model(1, {12'b0, d_b}, int'(sel_b));
        #1;
        check("a_f",     {31'b0, f_a},     32'(f_m[0]));
        check("a_fn",    {31'b0, fn_a},    32'(~f_m[0] & 1));
        check("a_ch",    {29'b0, ch_a},    32'(ch_m[0]));
        check("a_valid", {31'b0, valid_a}, 32'(v_m[0]));
        check("a_wrap",  {31'b0, wrap_a},  32'(w_m[0]));
        check("b_f",     {28'b0, f_b},     32'(f_m[1]));
        check("b_fn",    {28'b0, fn_b},    32'(~f_m[1] & 15));
        check("b_ch",    {29'b0, ch_b},    32'(ch_m[1]));
        check("b_valid", {31'b0, valid_b}, 32'(v_m[1]));
        check("b_wrap",  {31'b0, wrap_b},  32'(w_m[1]));
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n = 1'b0; G_n = 1'b0; mode = 1'b1;
        sel_a = '0; sel_b = '0;
        d_a = 8'b1010_0110; d_b = 20'hCBA98;
        steps(2);
        rst_n = 1'b1;
        steps(17);
        rst_n = 1'b0;
        steps(1);
        rst_n = 1'b1;
        steps(8);
        G_n = 1'b1;
        steps(4);
        G_n = 1'b0;
        steps(5);
        mode = 1'b0;
        for (int s = 0; s < 8; s++) begin
            sel_a = 3'(s);
            sel_b = 3'(s);
            step();
        end
        sel_b = 3'd6;
        steps(2);
        G_n = 1'b1;
        steps(2);
        G_n = 1'b0; mode = 1'b1;
        steps(10);
        rst_n = 1'b0;
        steps(1);
        rst_n = 1'b1;
        steps(4);
        for (int i = 0; i < 600; i++) begin
            rst_n = $urandom_range(0, 49) != 0;
            G_n   = $urandom_range(0, 4) == 0;
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            sel_a = 3'($urandom_range(0, 7));
            sel_b = 3'($urandom_range(0, 7));
            d_a   = 8'($urandom);
            d_b   = 20'($urandom);
            step();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
